// File: rtl/bus_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp) responder on the req/gnt/rvalid data bus.
// Latency: grant in the same cycle as the request, response (rvalid) exactly one cycle later.
// Backpressure: none; every request is granted immediately. Optional prescaler: BUS_TIMER_PRESCALE_EN.
module bus_timer #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter logic [63:0] ResetCmp  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o,
    output logic                 timer_irq_o
);

    localparam logic [2:0] OffMtimeLo = 3'd0;
    localparam logic [2:0] OffMtimeHi = 3'd1;
    localparam logic [2:0] OffCmpLo   = 3'd2;
    localparam logic [2:0] OffCmpHi   = 3'd3;
    localparam logic [2:0] OffCtrl    = 3'd4;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_irq;

    logic [2:0]  w_off;
    logic        w_mapped;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_tick;
    logic [31:0] w_wmask;
    logic [31:0] w_ctrl_val;
    logic [31:0] w_rd_val;
    logic [63:0] w_mtime_inc;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_cmp_nxt;
    logic [31:0] w_ctrl_new;

    // Only addr bits [4:2] select a register; the rest are don't-care.
    logic w_unused_addr;
    assign w_unused_addr = ^{addr_i[AddrWidth-1:5], addr_i[1:0]};

    assign gnt_o     = req_i;
    assign w_off     = addr_i[4:2];
    assign w_mapped  = (w_off <= OffCtrl);
    assign w_wr      = req_i & we_i & w_mapped;
    assign w_rd      = req_i & ~we_i & w_mapped;
    assign w_ctrl_wr = w_wr & (w_off == OffCtrl);
    assign w_wmask   = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

`ifdef BUS_TIMER_PRESCALE_EN
    logic [7:0] r_pre;
    logic [7:0] r_pcnt;

    // A tick fires on the last of PRESCALE+1 enabled cycles.
    assign w_tick     = r_en & (r_pcnt == r_pre);
    assign w_ctrl_val = {16'h0, r_pre, 7'h0, r_en};

    // Prescale counter restarts on any CTRL write and idles at 0 while disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pre  <= 8'h0;
            r_pcnt <= 8'h0;
        end else begin
            if (w_ctrl_wr) begin
                r_pre <= w_ctrl_new[15:8];
            end
            if (w_ctrl_wr || !r_en || w_tick) begin
                r_pcnt <= 8'h0;
            end else begin
                r_pcnt <= r_pcnt + 8'd1;
            end
        end
    end
`else
    assign w_tick     = r_en;
    assign w_ctrl_val = {31'h0, r_en};
`endif

    assign w_ctrl_new  = (w_ctrl_val & ~w_wmask) | (wdata_i & w_wmask);
    assign w_mtime_inc = r_mtime + {63'h0, w_tick};

    // Increment first, then let written bytes of the addressed word override the result.
    always_comb begin
        w_mtime_nxt = w_mtime_inc;
        w_cmp_nxt   = r_mtimecmp;
        if (w_wr) begin
            case (w_off)
                OffMtimeLo: w_mtime_nxt[31:0]  = (w_mtime_inc[31:0]  & ~w_wmask) | (wdata_i & w_wmask);
                OffMtimeHi: w_mtime_nxt[63:32] = (w_mtime_inc[63:32] & ~w_wmask) | (wdata_i & w_wmask);
                OffCmpLo:   w_cmp_nxt[31:0]    = (r_mtimecmp[31:0]   & ~w_wmask) | (wdata_i & w_wmask);
                OffCmpHi:   w_cmp_nxt[63:32]   = (r_mtimecmp[63:32]  & ~w_wmask) | (wdata_i & w_wmask);
                default:    ;
            endcase
        end
    end

    // Read mux over the current (pre-edge) register values.
    always_comb begin
        w_rd_val = 32'h0;
        case (w_off)
            OffMtimeLo: w_rd_val = r_mtime[31:0];
            OffMtimeHi: w_rd_val = r_mtime[63:32];
            OffCmpLo:   w_rd_val = r_mtimecmp[31:0];
            OffCmpHi:   w_rd_val = r_mtimecmp[63:32];
            OffCtrl:    w_rd_val = w_ctrl_val;
            default:    w_rd_val = 32'h0;
        endcase
    end

    // Timer state and the level interrupt, compared on current register values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime    <= 64'h0;
            r_mtimecmp <= ResetCmp;
            r_en       <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_cmp_nxt;
            if (w_ctrl_wr) begin
                r_en <= w_ctrl_new[0];
            end
            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    // One-cycle response; data and error are forced to 0 outside a response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            r_rvalid <= req_i;
            r_err    <= req_i & ~w_mapped;
            r_rdata  <= w_rd ? w_rd_val : 32'h0;
        end
    end

    assign rvalid_o    = r_rvalid;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign timer_irq_o = r_irq;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer against a cycle-level arithmetic reference model.
// Latency: checks the response one cycle after each request, and the interrupt every cycle.
// Backpressure: none expected; gnt must follow req combinationally.
module tb_bus_timer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        timer_irq_o;

    always #5 clk_i = ~clk_i;

    bus_timer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .timer_irq_o (timer_irq_o)
    );

    // Reference model state
    bit [63:0] m_time;
    bit [63:0] m_cmp;
    bit        m_en;
    bit [7:0]  m_pre;
    int        m_ecyc;     // enabled cycles since the last tick / prescale restart

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input bit [2:0] off);
        case (off)
            3'd0: return m_time[31:0];
            3'd1: return m_time[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
`ifdef BUS_TIMER_PRESCALE_EN
            3'd4: return {16'h0, m_pre, 7'h0, m_en};
`else
            3'd4: return {31'h0, m_en};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit [31:0] m_merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] be);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic m_reset();
        m_time = 64'h0;
        m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en   = 1'b0;
        m_pre  = 8'h0;
        m_ecyc = 0;
    endtask

    // One bus cycle: drive, predict, clock, compare. Starts and ends 1ns after a rising edge.
    task automatic cycle(input bit req, input bit we, input bit [3:0] be, input bit [2:0] off, input bit [31:0] wd);
        bit [31:0] a;
        bit [31:0] e_rdata;
        bit        e_err;
        bit        e_irq;
        bit        tick;
        bit [31:0] c;
        a       = $urandom;
        a[4:2]  = off;
        a[1:0]  = 2'b00;
        req_i   = req;
        we_i    = we;
        be_i    = be;
        addr_i  = a;
        wdata_i = wd;
        #1;
        check("gnt", gnt_o, req);
        e_err   = req && (off > 3'd4);
        e_rdata = (req && !we && off <= 3'd4) ? m_read(off) : 32'h0;
        e_irq   = (m_time >= m_cmp);

        // tick rate: every enabled cycle, or every PRESCALE+1 enabled cycles
`ifdef BUS_TIMER_PRESCALE_EN
        tick = m_en && (m_ecyc + 1 == int'(m_pre) + 1);
`else
        tick = m_en;
`endif
        if (!m_en || tick) m_ecyc = 0;
        else               m_ecyc = m_ecyc + 1;
        m_time = m_time + 64'(tick);
        if (req && we) begin
            case (off)
                3'd0: m_time[31:0]  = m_merge(m_time[31:0], wd, be);
                3'd1: m_time[63:32] = m_merge(m_time[63:32], wd, be);
                3'd2: m_cmp[31:0]   = m_merge(m_cmp[31:0], wd, be);
                3'd3: m_cmp[63:32]  = m_merge(m_cmp[63:32], wd, be);
                3'd4: begin
                    c      = m_merge(m_read(3'd4), wd, be);
                    m_en   = c[0];
`ifdef BUS_TIMER_PRESCALE_EN
                    m_pre  = c[15:8];
`endif
                    m_ecyc = 0;
                end
                default: ;
            endcase
        end

        @(posedge clk_i);
        #1;
        check("rvalid", rvalid_o, req);
        check("err", err_o, e_err);
        check("rdata", rdata_o, e_rdata);
        check("irq", timer_irq_o, e_irq);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
    endtask

    task automatic wr(input bit [2:0] off, input bit [31:0] wd);
        cycle(1'b1, 1'b1, 4'hF, off, wd);
    endtask

    task automatic rd(input bit [2:0] off);
        cycle(1'b1, 1'b0, 4'hF, off, 32'h0);
    endtask

    logic [31:0] snap1;
    logic [31:0] snap2;

    initial begin
        rst_ni  = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
        m_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_irq", timer_irq_o, 1'b0);
        rst_ni = 1'b1;

        // reset values of all five registers, back-to-back
        for (int i = 0; i < 5; i++) rd(3'(i));

        // free-running count, two reads five cycles apart
        wr(3'd4, 32'h1);
        idle(10);
        rd(3'd0);
        snap1 = rdata_o;
        idle(4);
        rd(3'd0);
        snap2 = rdata_o;
        check("delta5", snap2 - snap1, 32'd5);

        // carry LO -> HI, then a byte write coinciding with a tick
        wr(3'd4, 32'h0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h1);
        idle(1);
        rd(3'd1);
        rd(3'd0);
        cycle(1'b1, 1'b1, 4'b0010, 3'd0, 32'h0000_AB00);
        rd(3'd0);
        rd(3'd1);

        // interrupt crossing at 100 and clearing on compare raise
        wr(3'd4, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd2, 32'd100);
        wr(3'd4, 32'h1);
        idle(104);
        check("irq_hi", timer_irq_o, 1'b1);
        wr(3'd2, 32'd500);
        idle(2);
        check("irq_lo", timer_irq_o, 1'b0);

        // unmapped accesses: error, no side effects
        wr(3'd4, 32'h0);
        rd(3'd6);
        wr(3'd7, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) rd(3'(i));

        // prescale field (read back masked when the feature is absent)
        wr(3'd4, 32'h0000_0301);
        idle(13);
        rd(3'd4);
        rd(3'd0);
`ifdef BUS_TIMER_PRESCALE_EN
        check("ctrl_rb", m_read(3'd4), 32'h0000_0301);
`else
        check("ctrl_rb", m_read(3'd4), 32'h0000_0001);
`endif

        // reset while a response is outstanding: rvalid must drop
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        req_i  = 1'b0;
        #1;
        check("rst_drop", rvalid_o, 1'b0);
        m_reset();
        @(posedge clk_i);
        #1;
        check("rst_hold", rvalid_o, 1'b0);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) rd(3'(i));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [2:0]  off;
            bit [31:0] wd;
            off = 3'($urandom_range(0, 7));
            case (off)
                3'd1, 3'd3: wd = $urandom_range(0, 1);
                3'd4:       wd = ($urandom_range(0, 3) << 8) | $urandom_range(0, 1) | ($urandom & 32'hFFFF_0000);
                default:    wd = $urandom;
            endcase
            cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 1), 4'($urandom), off, wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
